// File: rtl/ysyx_24080006_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, between the IFU and
// an AXI4-Lite read port. Supports whole-cache invalidation and hit/miss counters.
module ysyx_24080006_icache #(
    parameter int unsigned IC_M = 2,
    parameter int unsigned IC_N = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_inst,
    output logic        ifu_err,
    input  logic        flush,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int unsigned IC_2  = 1 << IC_N;
    localparam int unsigned TAG_W = 32 - IC_M - IC_N;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      inst;
    } icache_t;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_AR, S_R, S_RESP} state_t;

    state_t           r_state;
    logic [31:0]      r_addr;
    logic [IC_2-1:0]  r_valid;
    logic             r_flush_pend;
    icache_t          r_line [IC_2];

    logic [IC_N-1:0]  w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_flush_now;
    logic             w_fire;
    logic             w_fill;
    logic             w_unused;

    assign w_idx       = r_addr[IC_M +: IC_N];
    assign w_tag       = r_addr[31 -: TAG_W];
    assign w_hit       = r_valid[w_idx] && (r_line[w_idx].tag == w_tag);
    assign w_flush_now = (r_state == S_IDLE) && (flush || r_flush_pend);
    assign w_fire      = ifu_req_valid && ifu_req_ready;
    assign w_fill      = (r_state == S_R) && rvalid && (rresp == 2'b00);
    assign w_unused    = ^r_addr[IC_M-1:0];

    // A pending or live invalidation blocks acceptance for that IDLE cycle.
    assign ifu_req_ready = (r_state == S_IDLE) && !w_flush_now;

    // Line payload needs no reset; the valid vector gates every read.
    always_ff @(posedge clock) begin
        if (w_fill) begin
            r_line[w_idx] <= '{tag: w_tag, inst: rdata};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_valid        <= '0;
            r_flush_pend   <= 1'b0;
            hit_cnt        <= '0;
            miss_cnt       <= '0;
            arvalid        <= 1'b0;
            araddr         <= '0;
            rready         <= 1'b0;
            ifu_resp_valid <= 1'b0;
            ifu_inst       <= '0;
            ifu_err        <= 1'b0;
        end else begin
            if (flush && (r_state != S_IDLE)) begin
                r_flush_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_flush_now) begin
                        r_valid      <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (w_fire) begin
                        r_addr  <= ifu_addr;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        ifu_inst       <= r_line[w_idx].inst;
                        ifu_err        <= 1'b0;
                        ifu_resp_valid <= 1'b1;
                        hit_cnt        <= hit_cnt + 32'd1;
                        r_state        <= S_RESP;
                    end else begin
                        araddr   <= {r_addr[31:2], 2'b00};
                        arvalid  <= 1'b1;
                        miss_cnt <= miss_cnt + 32'd1;
                        r_state  <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        rready         <= 1'b0;
                        ifu_resp_valid <= 1'b1;
                        if (rresp == 2'b00) begin
                            r_valid[w_idx] <= 1'b1;
                            ifu_inst       <= rdata;
                            ifu_err        <= 1'b0;
                        end else begin
                            ifu_inst <= '0;
                            ifu_err  <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (ifu_resp_ready) begin
                        ifu_resp_valid <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_24080006_icache.sv
// Randomized self-checking bench for the instruction cache, with a line-address
// reference model of the cache contents and an AXI-Lite read responder.
module tb_ysyx_24080006_icache;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_inst;
    logic        ifu_err, flush;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [31:0] hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;

    // Model: per index, whether a line is present and which word address it holds.
    bit          mv [64];
    logic [29:0] ml [64];
    logic [31:0] md [64];
    int unsigned m_hits, m_misses;

    ysyx_24080006_icache dut (
        .clock(clock), .reset_n(reset_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_inst(ifu_inst), .ifu_err(ifu_err), .flush(flush),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h3000_0000) return 32'h0000_0413;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    endtask

    task automatic model(input logic [31:0] a, input logic [1:0] resp, input bit flush_r,
                         output bit h, output logic [31:0] i, output logic e);
        int idx;
        idx = int'(a[7:2]);
        h = mv[idx] && (ml[idx] == a[31:2]);
        e = 1'b0;
        if (h) begin
            m_hits++;
            i = md[idx];
        end else begin
            m_misses++;
            if (resp == 2'b00) begin
                mv[idx] = 1'b1;
                ml[idx] = a[31:2];
                md[idx] = mem_word({a[31:2], 2'b00});
                i = md[idx];
            end else begin
                i = '0;
                e = 1'b1;
            end
            if (flush_r) model_flush();
        end
    endtask

    // Drives one fetch from a negedge and plays the bus slave; reports what it saw.
    task automatic fetch(input logic [31:0] a, input logic [1:0] resp, input int ar_dly,
                         input int r_dly, input int hold, input bit flush_r,
                         output bit saw_ar, output logic [31:0] ar_a, output logic [31:0] inst,
                         output logic err, output int lat, output bit stable, output bit to);
        int n;
        saw_ar = 1'b0; ar_a = '0; inst = '0; err = 1'b0; lat = 0; stable = 1'b1; to = 1'b0;
        ifu_addr = a;
        ifu_req_valid = 1'b1;
        n = 0;
        while (!ifu_req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!ifu_req_ready) begin
            to = 1'b1;
            ifu_req_valid = 1'b0;
            return;
        end
        @(negedge clock);
        ifu_req_valid = 1'b0;
        ifu_addr = $urandom;
        lat = 1;
        while (!ifu_resp_valid && lat < 200) begin
            if (arvalid && !saw_ar) begin
                saw_ar = 1'b1;
                ar_a = araddr;
                repeat (ar_dly) @(negedge clock);
                arready = 1'b1;
                @(negedge clock);
                arready = 1'b0;
                repeat (r_dly) @(negedge clock);
                rvalid = 1'b1;
                rresp = resp;
                rdata = mem_word(ar_a);
                flush = flush_r;
                @(negedge clock);
                rvalid = 1'b0;
                flush = 1'b0;
                rdata = $urandom;
                rresp = 2'($urandom);
                lat += ar_dly + r_dly + 2;
            end else begin
                @(negedge clock);
                lat++;
            end
        end
        if (!ifu_resp_valid) begin
            to = 1'b1;
            return;
        end
        inst = ifu_inst;
        err = ifu_err;
        repeat (hold) begin
            @(negedge clock);
            if (!ifu_resp_valid || ifu_inst !== inst || ifu_err !== err) stable = 1'b0;
        end
        ifu_resp_ready = 1'b1;
        @(negedge clock);
        ifu_resp_ready = 1'b0;
    endtask

    task automatic flush_idle();
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        @(negedge clock);
        model_flush();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (ifu_req_ready !== 1'b1 || ifu_resp_valid !== 1'b0 || arvalid !== 1'b0 ||
            rready !== 1'b0 || ifu_inst !== 32'h0 || ifu_err !== 1'b0 || araddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rv=%b arv=%b rr=%b inst=%h err=%b araddr=%h, expected 1 0 0 0 0 0 0",
                     ifu_req_ready, ifu_resp_valid, arvalid, rready, ifu_inst, ifu_err, araddr);
        end
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0 || ifu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_counters: hit=%0d miss=%0d ready=%b, expected 0 0 1", hit_cnt, miss_cnt, ifu_req_ready);
        end
        model_reset();
    endtask

    task automatic test_cold_miss();
        bit sa, st, to, eh; logic [31:0] aa, ins, ei; logic er, ee; int lat;
        model(32'h3000_0000, 2'b00, 1'b0, eh, ei, ee);
        fetch(32'h3000_0000, 2'b00, 1, 2, 0, 1'b0, sa, aa, ins, er, lat, st, to);
        checks++;
        if (to || !sa || aa !== 32'h3000_0000 || ins !== 32'h0000_0413 || er !== 1'b0 || miss_cnt !== 32'd1) begin
            errors++;
            $display("FAIL cold_miss: to=%0d ar=%0d araddr=%h inst=%h err=%b miss=%0d, expected 0 1 30000000 00000413 0 1",
                     to, sa, aa, ins, er, miss_cnt);
        end
    endtask

    task automatic test_hit();
        bit sa, st, to, eh; logic [31:0] aa, ins, ei; logic er, ee; int lat;
        model(32'h3000_0000, 2'b00, 1'b0, eh, ei, ee);
        fetch(32'h3000_0000, 2'b00, 0, 0, 0, 1'b0, sa, aa, ins, er, lat, st, to);
        checks++;
        if (to || sa || lat != 2 || ins !== ei || hit_cnt !== 32'd1) begin
            errors++;
            $display("FAIL hit_latency: to=%0d ar=%0d lat=%0d inst=%h hit=%0d, expected 0 0 2 %h 1", to, sa, lat, ins, hit_cnt, ei);
        end
        model(32'h3000_0003, 2'b00, 1'b0, eh, ei, ee);
        fetch(32'h3000_0003, 2'b00, 0, 0, 0, 1'b0, sa, aa, ins, er, lat, st, to);
        checks++;
        if (to || sa || ins !== 32'h0000_0413 || hit_cnt !== 32'(m_hits)) begin
            errors++;
            $display("FAIL hit_byte_offset: to=%0d ar=%0d inst=%h hit=%0d, expected 0 0 00000413 %0d", to, sa, ins, hit_cnt, m_hits);
        end
    endtask

    task automatic test_conflict();
        bit sa, st, to, eh; logic [31:0] aa, ins, ei; logic er, ee; int lat;
        logic [31:0] seq [3] = '{32'h3000_0100, 32'h3000_0000, 32'h3000_0000};
        for (int k = 0; k < 3; k++) begin
            model(seq[k], 2'b00, 1'b0, eh, ei, ee);
            fetch(seq[k], 2'b00, k, 1, 0, 1'b0, sa, aa, ins, er, lat, st, to);
            checks++;
            if (to || sa !== !eh || ins !== ei || er !== 1'b0 ||
                miss_cnt !== 32'(m_misses) || hit_cnt !== 32'(m_hits)) begin
                errors++;
                $display("FAIL conflict_%0d: to=%0d ar=%0d inst=%h miss=%0d hit=%0d, expected 0 %0d %h %0d %0d",
                         k, to, sa, ins, miss_cnt, hit_cnt, !eh, ei, m_misses, m_hits);
            end
        end
        checks++;
        if (miss_cnt !== 32'd3) begin
            errors++;
            $display("FAIL conflict_miss_total: miss=%0d, expected 3", miss_cnt);
        end
    endtask

    task automatic test_flush();
        bit sa, st, to, eh; logic [31:0] aa, ins, ei; logic er, ee; int lat, beats;
        for (int k = 0; k < 4; k++) begin
            model(32'h3000_0000 + 32'(k * 4), 2'b00, 1'b0, eh, ei, ee);
            fetch(32'h3000_0000 + 32'(k * 4), 2'b00, 0, 0, 0, 1'b0, sa, aa, ins, er, lat, st, to);
        end
        flush = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h3000_0000;
        #1;
        checks++;
        if (ifu_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks_ready: ready=%b, expected 0", ifu_req_ready);
        end
        @(negedge clock);
        flush = 1'b0;
        ifu_req_valid = 1'b0;
        #1;
        checks++;
        if (ifu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_no_accept: ready=%b, expected 1 (still idle)", ifu_req_ready);
        end
        model_flush();
        beats = 0;
        for (int k = 0; k < 4; k++) begin
            model(32'h3000_0000 + 32'(k * 4), 2'b00, 1'b0, eh, ei, ee);
            fetch(32'h3000_0000 + 32'(k * 4), 2'b00, 0, 1, 0, 1'b0, sa, aa, ins, er, lat, st, to);
            if (sa && !to && ins === ei) beats++;
        end
        checks++;
        if (beats != 4 || miss_cnt !== 32'(m_misses)) begin
            errors++;
            $display("FAIL flush_refetch: good_ar_beats=%0d miss=%0d, expected 4 %0d", beats, miss_cnt, m_misses);
        end
        model(32'h3000_0020, 2'b00, 1'b1, eh, ei, ee);
        fetch(32'h3000_0020, 2'b00, 0, 2, 0, 1'b1, sa, aa, ins, er, lat, st, to);
        checks++;
        if (to || !sa || ins !== ei || er !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_r_fill: to=%0d ar=%0d inst=%h err=%b, expected 0 1 %h 0", to, sa, ins, er, ei);
        end
        model(32'h3000_0020, 2'b00, 1'b0, eh, ei, ee);
        fetch(32'h3000_0020, 2'b00, 0, 0, 0, 1'b0, sa, aa, ins, er, lat, st, to);
        checks++;
        if (to || !sa || ins !== ei) begin
            errors++;
            $display("FAIL flush_in_r_refetch: to=%0d ar=%0d inst=%h, expected 0 1 %h", to, sa, ins, ei);
        end
    endtask

    task automatic test_bus_error();
        bit sa, st, to, eh; logic [31:0] aa, ins, ei; logic er, ee; int lat;
        model(32'h3000_0040, 2'b10, 1'b0, eh, ei, ee);
        fetch(32'h3000_0040, 2'b10, 1, 1, 0, 1'b0, sa, aa, ins, er, lat, st, to);
        checks++;
        if (to || !sa || aa !== 32'h3000_0040 || ins !== 32'h0 || er !== 1'b1) begin
            errors++;
            $display("FAIL bus_error: to=%0d ar=%0d araddr=%h inst=%h err=%b, expected 0 1 30000040 0 1", to, sa, aa, ins, er);
        end
        model(32'h3000_0040, 2'b00, 1'b0, eh, ei, ee);
        fetch(32'h3000_0040, 2'b00, 0, 0, 0, 1'b0, sa, aa, ins, er, lat, st, to);
        checks++;
        if (to || !sa || ins !== ei || er !== 1'b0) begin
            errors++;
            $display("FAIL bus_error_refetch: to=%0d ar=%0d inst=%h err=%b, expected 0 1 %h 0", to, sa, ins, er, ei);
        end
    endtask

    task automatic test_stall_and_reset();
        bit sa, st, to, eh; logic [31:0] aa, ins, ei; logic er, ee; int lat, n;
        model(32'h3000_0044, 2'b00, 1'b0, eh, ei, ee);
        fetch(32'h3000_0044, 2'b00, 0, 0, 5, 1'b0, sa, aa, ins, er, lat, st, to);
        checks++;
        if (to || !st || ins !== ei) begin
            errors++;
            $display("FAIL resp_stall: to=%0d stable=%0d inst=%h, expected 0 1 %h", to, st, ins, ei);
        end
        ifu_addr = 32'h3000_0080;
        ifu_req_valid = 1'b1;
        @(negedge clock);
        ifu_req_valid = 1'b0;
        n = 0;
        while (!arvalid && n < 20) begin
            @(negedge clock);
            n++;
        end
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        checks++;
        if (rready !== 1'b1) begin
            errors++;
            $display("FAIL reach_r_state: rready=%b, expected 1", rready);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ifu_req_ready !== 1'b1 || ifu_resp_valid !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0 ||
            ifu_inst !== 32'h0 || ifu_err !== 1'b0 || araddr !== 32'h0 || hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_miss: ready=%b rv=%b arv=%b rr=%b inst=%h err=%b araddr=%h hit=%0d miss=%0d, expected all reset values",
                     ifu_req_ready, ifu_resp_valid, arvalid, rready, ifu_inst, ifu_err, araddr, hit_cnt, miss_cnt);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        model_reset();
        model(32'h3000_0044, 2'b00, 1'b0, eh, ei, ee);
        fetch(32'h3000_0044, 2'b00, 0, 0, 0, 1'b0, sa, aa, ins, er, lat, st, to);
        checks++;
        if (to || !sa || ins !== ei || miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_miss: to=%0d ar=%0d inst=%h miss=%0d hit=%0d, expected 0 1 %h 1 0", to, sa, ins, miss_cnt, hit_cnt, ei);
        end
    endtask

    task automatic test_random();
        bit sa, st, to, eh, fr; logic [31:0] a, aa, ins, ei; logic er, ee; logic [1:0] rs; int lat;
        for (int k = 0; k < 80; k++) begin
            a = 32'h3000_0000 | (32'($urandom_range(0, 5)) << 2) | (32'($urandom_range(0, 2)) << 8) |
                32'($urandom_range(0, 3));
            rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            fr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 11) == 0) flush_idle();
            model(a, rs, fr, eh, ei, ee);
            fetch(a, rs, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), fr,
                  sa, aa, ins, er, lat, st, to);
            checks++;
            if (to || sa !== !eh || (sa && aa !== {a[31:2], 2'b00}) || ins !== ei || er !== ee ||
                (eh && lat != 2) || !st) begin
                errors++;
                $display("FAIL random_%0d addr=%h: to=%0d ar=%0d araddr=%h inst=%h err=%b lat=%0d stable=%0d, expected ar=%0d inst=%h err=%b",
                         k, a, to, sa, aa, ins, er, lat, st, !eh, ei, ee);
            end
            checks++;
            if (hit_cnt !== 32'(m_hits) || miss_cnt !== 32'(m_misses)) begin
                errors++;
                $display("FAIL random_counters_%0d: hit=%0d miss=%0d, expected %0d %0d", k, hit_cnt, miss_cnt, m_hits, m_misses);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ifu_req_valid = 1'b0;
        ifu_addr = '0;
        ifu_resp_ready = 1'b0;
        flush = 1'b0;
        arready = 1'b0;
        rvalid = 1'b0;
        rdata = '0;
        rresp = 2'b00;
        model_reset();
        @(negedge clock);
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_bus_error();
        test_stall_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
